// File: rtl/madd_pkg.sv
// Shared constants and helpers for the pipelined multi-operand modular adder.
package madd_pkg;

    localparam int WIDTH_MIN   = 8;
    localparam int WIDTH_MAX   = 64;
    localparam int NUM_OPS_MIN = 2;
    localparam int NUM_OPS_MAX = 8;
    localparam int TAG_W_MIN   = 1;

    // Carry-out width: enough headroom for the sum of n full-scale operands.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/madd_pipe_n_csa_tree.sv
// Combinational carry-save reduction of NUM_OPS vectors to a sum/carry pair.
module csa_tree #(
    parameter int WIDTH_EXT = 35,
    parameter int NUM_OPS   = 5
) (
    input  logic [NUM_OPS*WIDTH_EXT-1:0] ops,
    output logic [WIDTH_EXT-1:0]         sum,
    output logic [WIDTH_EXT-1:0]         car
);

    logic [WIDTH_EXT-1:0] row_s [NUM_OPS-1];
    logic [WIDTH_EXT-1:0] row_c [NUM_OPS-1];

    assign row_s[0] = ops[0 +: WIDTH_EXT];
    assign row_c[0] = ops[WIDTH_EXT +: WIDTH_EXT];

    // Each row folds one more operand into the running pair; the carry
    // shift cannot drop a set bit because WIDTH_EXT holds the exact total.
    for (genvar i = 0; i < NUM_OPS - 2; i++) begin : g_row
        logic [WIDTH_EXT-1:0] a;
        logic [WIDTH_EXT-1:0] b;
        logic [WIDTH_EXT-1:0] d;
        assign a = row_s[i];
        assign b = row_c[i];
        assign d = ops[(i+2)*WIDTH_EXT +: WIDTH_EXT];
        assign row_s[i+1] = a ^ b ^ d;
        assign row_c[i+1] = ((a & b) | (a & d) | (b & d)) << 1;
    end

    assign sum = row_s[NUM_OPS-2];
    assign car = row_c[NUM_OPS-2];

endmodule

// File: rtl/madd_pipe_n.sv
// Two-stage multi-operand modular adder: CSA tree register, then CPA register.
module madd_pipe_n
    import madd_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_OPS = 5,
    parameter  int TAG_W   = 4,
    localparam int CW      = clog2_min1(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [CW-1:0]            out_hi,
    output logic                     out_ovfl,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int WE = WIDTH + CW;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("madd_pipe_n: WIDTH out of range");
    end
    if (NUM_OPS < NUM_OPS_MIN || NUM_OPS > NUM_OPS_MAX) begin : g_bad_ops
        $error("madd_pipe_n: NUM_OPS out of range");
    end
    if (TAG_W < TAG_W_MIN) begin : g_bad_tag
        $error("madd_pipe_n: TAG_W out of range");
    end

    logic [NUM_OPS*WE-1:0] ops_ext;
    logic [WE-1:0]         tree_sum;
    logic [WE-1:0]         tree_car;
    logic [WE-1:0]         cpa;

    logic                  s1_valid;
    logic [WE-1:0]         s1_sum;
    logic [WE-1:0]         s1_car;
    logic [TAG_W-1:0]      s1_tag;
    logic                  s2_valid;

    logic                  s1_adv;
    logic                  s2_adv;
    logic                  accept;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
        assign ops_ext[k*WE +: WE] = {{CW{1'b0}}, in_ops[k*WIDTH +: WIDTH]};
    end

    csa_tree #(
        .WIDTH_EXT (WE),
        .NUM_OPS   (NUM_OPS)
    ) u_tree (
        .ops (ops_ext),
        .sum (tree_sum),
        .car (tree_car)
    );

    // Handshake: a transfer happens on any edge where valid && ready. Each
    // stage advances when the stage after it is empty or draining, so
    // in_ready depends on out_ready and the valid bits only, never on in_valid.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    assign cpa       = s1_sum + s1_car;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum   <= '0;
            s1_car   <= '0;
            s1_tag   <= '0;
            out_sum  <= '0;
            out_hi   <= '0;
            out_ovfl <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (accept) begin
                s1_sum <= tree_sum;
                s1_car <= tree_car;
                s1_tag <= in_tag;
            end
            if (s1_valid && s1_adv) begin
                out_sum  <= cpa[WIDTH-1:0];
                out_hi   <= cpa[WIDTH +: CW];
                out_ovfl <= |cpa[WIDTH +: CW];
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: doc/madd_pipe_n.md
Name: madd_pipe_n

Overview:
- Parametrised, pipelined multi-operand modular adder; successor to the fixed 4-operand, 32-bit combinational adder.
- Accepts NUM_OPS operands of WIDTH bits per transaction under a valid/ready handshake.
- Reduces the operands through a carry-save tree into a registered sum/carry pair, then resolves them with a registered carry-propagate adder.
- Used in the SHA-256 round datapath, e.g. T1 = h + Σ1 + Ch + K + W with NUM_OPS=5, where throughput and timing closure need a register between the tree and the CPA.

Parameters:
- WIDTH, 32, operand and result width in bits; range 8..64.
- NUM_OPS, 5, operands per transaction; range 2..8.
- TAG_W, 4, width of the sideband tag carried alongside each transaction; range ≥1.
- Derived constant CW = max(1, clog2(NUM_OPS)), the carry-out width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_ops  in  NUM_OPS*WIDTH  operands packed; operand k occupies bits [k*WIDTH +: WIDTH].
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  sum of all operands modulo 2^WIDTH.
- out_hi  out  CW  bits [WIDTH +: CW] of the exact sum (discarded carries).
- out_ovfl  out  1  1 when out_hi != 0.
- out_tag  out  TAG_W  tag of the transaction currently on the output.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_sum=0, out_hi=0, out_ovfl=0, out_tag=0; in_ready=1 once reset is deasserted.
- Exact sum width is WIDTH+CW. Operands are zero-extended to WIDTH+CW before the tree, so the tree never loses a carry. Arithmetic is unsigned.
- Stage 1 (tree):
  - Combinational 3:2 compressor tree reduces NUM_OPS vectors to a sum vector and a carry vector, each WIDTH+CW bits.
  - Both vectors and in_tag are registered into s1 on the accept condition in_valid && in_ready.
  - For NUM_OPS=2 the tree is a pass-through.
- Stage 2 (CPA):
  - s1_sum + s1_car computed in WIDTH+CW bits.
  - Result is registered into the output regs when s1_valid && s1_adv.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid || s1_adv. This is combinational from out_ready; it has no combinational path from in_valid.
- Latency: exactly 2 cycles from the accept edge to out_valid=1 when unstalled. Throughput is 1 transaction per cycle.
- Transfer: a result completes on the edge where out_valid && out_ready. Without a new s1 entry, out_valid clears on that edge.
- Stall: while out_valid && !out_ready, out_sum, out_hi, out_ovfl and out_tag hold stable, and s1 holds its contents. Up to 2 transactions are buffered; the third sees in_ready=0.
- Simultaneous events:
  - Accept into s1 and s1→s2 move on the same edge are both permitted.
  - Output transfer and a new result load on the same edge: the new result replaces the old one, and out_valid stays 1.
- Order is strictly FIFO. No transaction is dropped or duplicated.
- Reset mid-operation: all in-flight transactions are discarded immediately on rst assertion, with no partial outputs after release.
- X-safety: data registers load only on advance. Valid bits are never derived from data.

Decomposition:
- Package madd_pkg holds:
  - function clog2_min1(n), returning max(1, clog2(n));
  - localparams for the parameter range limits, which elaborate-time assertions check.
- One combinational sub-module, csa_tree. It is parameterised by WIDTH_EXT and NUM_OPS, generate-built from 3:2 compressor rows, and outputs a sum/carry pair.
- Pipeline registers and handshake logic stay in madd_pipe_n.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release → out_valid=0, out_sum=0, out_hi=0, in_ready=1. Pulse rst asynchronously between edges → outputs clear without waiting for a clock edge.
- Basic sum (W=32, N=5): ops 1,2,3,4,5, tag 0x3, out_ready=1 → 2 cycles later out_valid=1, out_sum=0x0000000F, out_hi=0, out_ovfl=0, out_tag=0x3.
- Overflow: five ops of 0xFFFFFFFF → out_sum=0xFFFFFFFB, out_hi=4, out_ovfl=1.
- Streaming: 4 back-to-back transactions with tags 0..3 and random ops, out_ready=1 → 4 consecutive out_valid cycles, tags in order 0,1,2,3, and each sum matches the reference model.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 → exactly 2 accepted, then in_ready=0; the output stays stable. Then out_ready=1 → results drain in order with no loss or duplication, and in_ready returns to 1 in the same cycle.
- Reset mid-flight: 2 transactions in flight, assert rst for 1 cycle → out_valid=0 at once. No stale result appears after release; a new transaction of ops all 0x1 gives out_sum=5.
